hpdcache_sram_req_arbiter: RTL and testbench
============================================

Name: hpdcache_sram_req_arbiter

Overview:
- Shares one single-port, byte-enable-writable SRAM macro among NREQ requesters, for example the refill, core-access and flush paths of a data or directory array.
- Optionally zero-initialises the whole array after reset, before any requester is served.
- Round-robin arbitration with a valid/ready request handshake.
- Read data returns one cycle after the granted read and is tagged to the requester that issued it.

Parameters:
- ADDR_SIZE, 6: SRAM address width.
- DATA_SIZE, 64: SRAM word width; a multiple of 8.
- DEPTH, 2**ADDR_SIZE: number of SRAM words.
- NREQ, 2: number of requesters, at least 1.
- INIT_ON_RESET, 1: 1 zero-fills the array after reset; 0 skips initialisation.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid_i  in  NREQ  per-requester request valid.
- req_ready_o  out  NREQ  per-requester grant; the request is accepted in the cycle where valid and ready are both high.
- req_we_i  in  NREQ  1 = write, 0 = read.
- req_addr_i  in  NREQ*ADDR_SIZE  packed addresses; requester k occupies slice k.
- req_wdata_i  in  NREQ*DATA_SIZE  packed write data.
- req_be_i  in  NREQ*DATA_SIZE/8  packed byte enables.
- rsp_valid_o  out  NREQ  one-hot; read data valid for requester k.
- rsp_rdata_o  out  DATA_SIZE  read data, shared by all requesters.
- init_done_o  out  1  high once the array is ready for traffic.
- sram_cs_o  out  1  SRAM chip select.
- sram_we_o  out  1  SRAM write enable.
- sram_addr_o  out  ADDR_SIZE  SRAM address.
- sram_wdata_o  out  DATA_SIZE  SRAM write data.
- sram_be_o  out  DATA_SIZE/8  SRAM byte enables.
- sram_rdata_i  in  DATA_SIZE  SRAM read data, valid one cycle after a read with cs high.

Behaviour:
- Reset values:
  - state = INIT if INIT_ON_RESET, else RUN.
  - init counter = 0, round-robin pointer = 0, rsp_valid_o = 0.
  - init_done_o = 0 when INIT_ON_RESET = 1; 1 when INIT_ON_RESET = 0.
  - Reset asserted at any time, including mid-INIT, restarts from these values.
- Two-state FSM: INIT and RUN.
- INIT state:
  - sram_cs_o = 1, sram_we_o = 1, sram_addr_o = counter, sram_wdata_o = 0, sram_be_o = all ones.
  - req_ready_o = 0 for all requesters.
  - The counter increments every cycle.
  - In the cycle where counter == DEPTH-1, the FSM moves to RUN and the counter stops.
  - Exactly DEPTH write cycles occur. init_done_o registers to 1 on the following edge.
  - The counter is ADDR_SIZE+1 bits wide so that DEPTH = 2**ADDR_SIZE terminates correctly.
- RUN state:
  - Grant selection is combinational: the first asserted req_valid_i at or after the round-robin pointer, searching upward with wrap-around, gets req_ready_o.
  - At most one ready bit is high. ready never rises without the matching valid.
  - sram_cs_o = |req_valid_i. sram_we, addr, wdata and be come from the granted requester's slice.
  - When cs is low, the other SRAM outputs are don't-care and are driven to 0.
  - On a grant to requester g, the pointer becomes g+1 mod NREQ. With no grant, the pointer holds.
  - A lone requester valid every cycle is granted every cycle; there are no bubbles.
- Read response:
  - A granted read (we = 0) sets rsp_valid_o[g] = 1 on the next cycle. rsp_rdata_o = sram_rdata_i, passed through unregistered.
  - Writes produce no response.
  - Back-to-back reads give back-to-back responses, each tagged to its own requester.
  - No backpressure on responses: requesters must sink them.
- Hazards: a write followed by a read to the same address on the next cycle returns the new data, because the SRAM is write-first by sequencing. No forwarding is needed.
- Throughput: one access per cycle. Latency is 0 cycles to grant and 1 cycle to read data.

Decomposition:
- Package hpdcache_sram_arb_pkg holds:
  - the state enum (INIT, RUN);
  - a helper function to compute the byte-enable width.
- Sub-module hpdcache_rr_arbiter (parameter NREQ):
  - inputs: req vector, pointer;
  - outputs: one-hot grant and granted index;
  - combinational; the pointer register lives in the parent.

Test Plan:
- INIT_ON_RESET=1, DEPTH=64: release reset → 64 consecutive writes to addr 0..63 with wdata 0 and be 0xFF. init_done rises on cycle 65. All ready low throughout.
- Requesters 0 and 1 both valid continuously, reads to 0x05 and 0x09 → grants alternate 0,1,0,1. rsp_valid alternates one cycle later with the matching stored data.
- Requester 1 writes 0xDEAD_BEEF to addr 3 with be 0x0F, then reads addr 3 → rsp_valid[1] with rdata 0x00000000_DEADBEEF, upper bytes still 0.
- Only requester 0 valid for 10 cycles → 10 grants with no bubble; the pointer still rotates to 1 after each grant.
- Reset asserted at INIT counter 20 → init restarts at address 0; init_done stays 0 until 64 new writes complete.
- INIT_ON_RESET=0 → init_done is 1 out of reset and a read request is granted in the first cycle.

Source files
------------

// File: rtl/hpdcache_sram_arb_pkg.sv
// Shared types and helpers for the SRAM request arbiter.
package hpdcache_sram_arb_pkg;

  typedef enum logic {
    INIT,
    RUN
  } arb_state_e;

  function automatic int unsigned be_width(input int unsigned data_size);
    return data_size / 8;
  endfunction

endpackage

// File: rtl/hpdcache_rr_arbiter.sv
// Combinational round-robin grant: first asserted request at or after the
// pointer, searching upward with wrap-around.
module hpdcache_rr_arbiter #(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDXW-1:0] gnt_idx_o
);

  logic found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      int unsigned k;
      k = (32'(ptr_i) + i) % NREQ;
      if (!found && req_i[k]) begin
        found     = 1'b1;
        gnt_o[k]  = 1'b1;
        gnt_idx_o = IDXW'(k);
      end
    end
  end

endmodule

// File: rtl/hpdcache_sram_req_arbiter.sv
// Shares one single-port byte-enable SRAM among NREQ requesters, with optional
// zero-fill after reset and one-cycle tagged read responses.
module hpdcache_sram_req_arbiter
  import hpdcache_sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_SIZE     = 6,
  parameter int unsigned DATA_SIZE     = 64,
  parameter int unsigned DEPTH         = 2**ADDR_SIZE,
  parameter int unsigned NREQ          = 2,
  parameter int unsigned INIT_ON_RESET = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NREQ-1:0]                   req_valid_i,
  output logic [NREQ-1:0]                   req_ready_o,
  input  logic [NREQ-1:0]                   req_we_i,
  input  logic [NREQ*ADDR_SIZE-1:0]         req_addr_i,
  input  logic [NREQ*DATA_SIZE-1:0]         req_wdata_i,
  input  logic [NREQ*be_width(DATA_SIZE)-1:0] req_be_i,
  output logic [NREQ-1:0]                   rsp_valid_o,
  output logic [DATA_SIZE-1:0]              rsp_rdata_o,
  output logic                              init_done_o,
  output logic                              sram_cs_o,
  output logic                              sram_we_o,
  output logic [ADDR_SIZE-1:0]              sram_addr_o,
  output logic [DATA_SIZE-1:0]              sram_wdata_o,
  output logic [be_width(DATA_SIZE)-1:0]    sram_be_o,
  input  logic [DATA_SIZE-1:0]              sram_rdata_i
);

  localparam int unsigned BEW  = be_width(DATA_SIZE);
  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // One extra counter bit keeps DEPTH = 2**ADDR_SIZE representable.
  localparam logic [ADDR_SIZE:0] LAST = (ADDR_SIZE+1)'(DEPTH - 1);

  arb_state_e          state_q;
  logic [ADDR_SIZE:0]  cnt_q;
  logic [IDXW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]     rsp_valid_q;
  logic                init_done_q;
  logic [NREQ-1:0]     gnt;
  logic [IDXW-1:0]     gnt_idx;

  hpdcache_rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .req_i     (req_valid_i),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign ptr_d = IDXW'((32'(gnt_idx) + 32'd1) % NREQ);

  always_comb begin
    req_ready_o  = '0;
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (state_q == INIT) begin
      sram_cs_o   = 1'b1;
      sram_we_o   = 1'b1;
      sram_addr_o = cnt_q[ADDR_SIZE-1:0];
      sram_be_o   = '1;
    end else begin
      req_ready_o = gnt;
      if (|req_valid_i) begin
        sram_cs_o    = 1'b1;
        sram_we_o    = req_we_i[gnt_idx];
        sram_addr_o  = req_addr_i[gnt_idx*ADDR_SIZE +: ADDR_SIZE];
        sram_wdata_o = req_wdata_i[gnt_idx*DATA_SIZE +: DATA_SIZE];
        sram_be_o    = req_be_i[gnt_idx*BEW +: BEW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= (INIT_ON_RESET != 0) ? INIT : RUN;
      cnt_q       <= '0;
      ptr_q       <= '0;
      rsp_valid_q <= '0;
      init_done_q <= (INIT_ON_RESET == 0);
    end else begin
      case (state_q)
        INIT: begin
          rsp_valid_q <= '0;
          if (cnt_q == LAST) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          rsp_valid_q <= req_we_i[gnt_idx] ? '0 : gnt;
          if (|gnt) ptr_q <= ptr_d;
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = sram_rdata_i;
  assign init_done_o = init_done_q;

endmodule

// File: tb/tb_hpdcache_sram_req_arbiter.sv
// Randomized bench for hpdcache_sram_req_arbiter against a behavioural
// array/round-robin model, plus a second instance without init.
module tb_hpdcache_sram_req_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 6;
  localparam int DW   = 64;
  localparam int BW   = 8;
  localparam int DEP  = 64;
  localparam logic [DW-1:0] B_RDATA = 64'h0123_4567_89AB_CDEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    valid, we, ready, rsp_valid;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ*BW-1:0] be;
  logic [DW-1:0]      rsp_rdata, s_wdata, s_rdata;
  logic               init_done, s_cs, s_we;
  logic [AW-1:0]      s_addr;
  logic [BW-1:0]      s_be;

  logic [NREQ-1:0]    b_valid, b_ready, b_rsp_valid;
  logic [NREQ*AW-1:0] b_addr;
  logic [DW-1:0]      b_rsp_rdata, b_wdata_o;
  logic               b_init_done, b_cs, b_we;
  logic [AW-1:0]      b_saddr;
  logic [BW-1:0]      b_be_o;

  hpdcache_sram_req_arbiter #(
    .ADDR_SIZE (AW), .DATA_SIZE (DW), .DEPTH (DEP), .NREQ (NREQ), .INIT_ON_RESET (1)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .req_valid_i (valid), .req_ready_o (ready), .req_we_i (we),
    .req_addr_i (addr), .req_wdata_i (wdata), .req_be_i (be),
    .rsp_valid_o (rsp_valid), .rsp_rdata_o (rsp_rdata), .init_done_o (init_done),
    .sram_cs_o (s_cs), .sram_we_o (s_we), .sram_addr_o (s_addr),
    .sram_wdata_o (s_wdata), .sram_be_o (s_be), .sram_rdata_i (s_rdata)
  );

  hpdcache_sram_req_arbiter #(
    .ADDR_SIZE (AW), .DATA_SIZE (DW), .DEPTH (DEP), .NREQ (NREQ), .INIT_ON_RESET (0)
  ) dut_noinit (
    .clk (clk), .rst_n (rst_n),
    .req_valid_i (b_valid), .req_ready_o (b_ready), .req_we_i ('0),
    .req_addr_i (b_addr), .req_wdata_i ('0), .req_be_i ('0),
    .rsp_valid_o (b_rsp_valid), .rsp_rdata_o (b_rsp_rdata), .init_done_o (b_init_done),
    .sram_cs_o (b_cs), .sram_we_o (b_we), .sram_addr_o (b_saddr),
    .sram_wdata_o (b_wdata_o), .sram_be_o (b_be_o), .sram_rdata_i (B_RDATA)
  );

  // Environment SRAM macro for the main instance, preloaded with garbage.
  logic [DW-1:0] sram_mem [DEP];
  initial for (int i = 0; i < DEP; i++) sram_mem[i] = {$urandom, $urandom};
  always @(posedge clk) begin
    if (s_cs) begin
      if (s_we) begin
        for (int b = 0; b < BW; b++)
          if (s_be[b]) sram_mem[s_addr][b*8 +: 8] <= s_wdata[b*8 +: 8];
      end else begin
        s_rdata <= sram_mem[s_addr];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: init progress, rotating priority, array contents, pending response.
  bit            m_init;
  int            m_cnt, m_ptr;
  logic [DW-1:0] m_mem [DEP];
  logic [NREQ-1:0] m_rsp;
  logic [DW-1:0] m_rdata;

  task automatic model_reset();
    m_init = 1'b1; m_cnt = 0; m_ptr = 0; m_rsp = '0; m_rdata = '0;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] w,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [BW-1:0] e0, input logic [BW-1:0] e1);
    valid = v; we = w; addr = {a1, a0}; wdata = {d1, d0}; be = {e1, e0};
  endtask

  task automatic drive_rand(input int amax);
    drive(2'($urandom), 2'($urandom), AW'($urandom_range(amax)), AW'($urandom_range(amax)),
          {$urandom, $urandom}, {$urandom, $urandom}, BW'($urandom), BW'($urandom));
  endtask

  // Called at posedge+1 with inputs applied; checks this cycle, then advances.
  task automatic step();
    int g;
    logic [NREQ-1:0] e_ready;
    logic e_cs, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [BW-1:0] e_be;
    #1;
    g = -1;
    e_ready = '0; e_cs = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0; e_be = '0;
    if (m_init) begin
      e_cs = 1'b1; e_we = 1'b1; e_addr = AW'(m_cnt); e_be = '1;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        int k;
        k = (m_ptr + i) % NREQ;
        if (g < 0 && valid[k]) g = k;
      end
      if (g >= 0) begin
        e_ready[g] = 1'b1; e_cs = 1'b1; e_we = we[g];
        e_addr = addr[g*AW +: AW]; e_wd = wdata[g*DW +: DW]; e_be = be[g*BW +: BW];
      end
    end
    chk("ready", DW'(ready), DW'(e_ready));
    chk("sram_cs", DW'(s_cs), DW'(e_cs));
    chk("sram_we", DW'(s_we), DW'(e_we));
    chk("sram_addr", DW'(s_addr), DW'(e_addr));
    chk("sram_wdata", s_wdata, e_wd);
    chk("sram_be", DW'(s_be), DW'(e_be));
    chk("init_done", DW'(init_done), DW'(!m_init));
    chk("rsp_valid", DW'(rsp_valid), DW'(m_rsp));
    if (m_rsp != '0) chk("rsp_rdata", rsp_rdata, m_rdata);
    m_rsp = '0;
    if (m_init) begin
      m_mem[m_cnt] = '0;
      if (m_cnt == DEP - 1) m_init = 1'b0;
      else m_cnt++;
    end else if (g >= 0) begin
      m_ptr = (g + 1) % NREQ;
      if (e_we) begin
        for (int b = 0; b < BW; b++)
          if (e_be[b]) m_mem[e_addr][b*8 +: 8] = e_wd[b*8 +: 8];
      end else begin
        m_rsp[g] = 1'b1;
        m_rdata = m_mem[e_addr];
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    drive('0, '0, '0, '0, '0, '0, '0, '0);
    b_valid = '0; b_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_init_done", DW'(init_done), '0);
    chk("rst_ready", DW'(ready), '0);
    chk("rst_rsp_valid", DW'(rsp_valid), '0);
    chk("rst_addr", DW'(s_addr), '0);
    chk("b_rst_init_done", DW'(b_init_done), 64'd1);
    chk("b_rst_rsp_valid", DW'(b_rsp_valid), '0);

    // Release reset; the non-init instance serves a read in its first cycle.
    rst_n = 1'b1;
    model_reset();
    b_valid = 2'b01; b_addr = {6'd0, 6'd2};
    drive_rand(63);
    #1;
    chk("b_first_ready", DW'(b_ready), 64'd1);
    chk("b_first_cs", DW'(b_cs), 64'd1);
    chk("b_first_we", DW'(b_we), '0);
    chk("b_first_addr", DW'(b_saddr), 64'd2);
    step();
    chk("b_first_rsp", DW'(b_rsp_valid), 64'd1);
    chk("b_first_rdata", b_rsp_rdata, B_RDATA);
    b_valid = '0;

    // Remaining init cycles with random traffic that must be held off.
    while (m_init) begin drive_rand(63); step(); end
    chk("init_done_after_fill", DW'(init_done), 64'd1);

    // Seed two words, then contend on reads of them.
    drive(2'b01, 2'b01, 6'h05, '0, 64'h1111_2222_3333_4444, '0, 8'hFF, '0); step();
    drive(2'b10, 2'b10, '0, 6'h09, '0, 64'h5555_6666_7777_8888, '0, 8'hFF); step();
    for (int i = 0; i < 6; i++) begin
      drive(2'b11, 2'b00, 6'h05, 6'h09, '0, '0, '0, '0); step();
    end

    // Partial-byte write then read of the same word.
    drive(2'b10, 2'b10, '0, 6'h03, '0, 64'hDEAD_BEEF, '0, 8'h0F); step();
    drive(2'b10, 2'b00, '0, 6'h03, '0, '0, '0, '0); step();
    chk("partial_write_rdata", rsp_rdata, 64'h0000_0000_DEAD_BEEF);
    chk("partial_write_rsp", DW'(rsp_valid), 64'd2);

    // Lone requester: granted every cycle.
    for (int i = 0; i < 10; i++) begin
      drive(2'b01, 2'($urandom) & 2'b01, AW'($urandom_range(7)), '0,
            {$urandom, $urandom}, '0, BW'($urandom), '0);
      step();
    end

    // Random traffic on a narrow address range to hit write-then-read hazards.
    for (int i = 0; i < 300; i++) begin drive_rand(3); step(); end

    // Reset in the middle of init.
    rst_n = 1'b0; #1; rst_n = 1'b1; #1; rst_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin drive_rand(63); step(); end
    rst_n = 1'b0;
    #1;
    chk("midinit_rst_addr", DW'(s_addr), '0);
    chk("midinit_rst_done", DW'(init_done), '0);
    chk("midinit_rst_ready", DW'(ready), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    while (m_init) begin drive_rand(63); step(); end
    for (int i = 0; i < 100; i++) begin drive_rand(63); step(); end
    drive('0, '0, '0, '0, '0, '0, '0, '0); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
